// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin subtractor, LSB first, one bit per clock.
// Valid/ready handshake on operand and result sides.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borr,
   output logic             ovf
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sr, b_sr;
   logic             br;
   logic [CNT_W-1:0] cnt;
   logic             a_msb, b_msb;
   logic             d_bit, br_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = RUN;
         end
         RUN: begin
            if (cnt == LAST) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Half-subtractor cell extended with the registered borrow.
   always_comb begin
      d_bit = a_sr[0] ^ b_sr[0] ^ br;
      br_nx = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr  <= '0;
         b_sr  <= '0;
         br    <= 1'b0;
         cnt   <= '0;
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         diff  <= '0;
         borr  <= 1'b0;
         ovf   <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         a_sr  <= a;
         b_sr  <= b;
         br    <= bin;
         cnt   <= '0;
         a_msb <= a[WIDTH-1];
         b_msb <= b[WIDTH-1];
      end else if (state == RUN) begin
         diff <= {d_bit, diff[WIDTH-1:1]};
         a_sr <= a_sr >> 1;
         b_sr <= b_sr >> 1;
         br   <= br_nx;
         cnt  <= cnt + 1'b1;
         // On the last bit d_bit is the result MSB, so flags are final here.
         if (cnt == LAST) begin
            borr <= br_nx;
            ovf  <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor against an
// arithmetic reference model.
module tb_serial_subtractor;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a, b;
   logic         bin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         borr;
   logic         ovf;

   int checks = 0;
   int errors = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borr      (borr),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Returns {ovf, borr, diff} from integer arithmetic on the operands.
   function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mbin);
      int ur, sr, sa, sb;
      logic [W-1:0] d;
      logic ub, so;
      ur = int'(ma) - int'(mb) - int'(mbin);
      d  = ur[W-1:0];
      ub = (ur < 0);
      sa = ma[W-1] ? int'(ma) - (1 << W) : int'(ma);
      sb = mb[W-1] ? int'(mb) - (1 << W) : int'(mb);
      sr = sa - sb - int'(mbin);
      so = (sr < -(1 << (W-1))) || (sr > (1 << (W-1)) - 1);
      return {so, ub, d};
   endfunction

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                         input int hold);
      logic [W+1:0] exp;
      logic [W-1:0] held;
      int n;
      exp = model(ta, tb_, tbin);
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (!in_ready) begin
         check("wait_in_ready", 0, 1);
         return;
      end
      a = ta; b = tb_; bin = tbin; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      n = 0;
      while (!out_valid && n < 4*W) begin
         check("run_in_ready", 32'(in_ready), 0);
         @(posedge clk); #1; n++;
      end
      if (!out_valid) begin
         check("wait_out_valid", 0, 1);
         return;
      end
      check("latency", n, W);
      check("diff", 32'(diff), 32'(exp[W-1:0]));
      check("borr", 32'(borr), 32'(exp[W]));
      check("ovf", 32'(ovf), 32'(exp[W+1]));
      held = diff;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
         @(posedge clk); #1;
         check("hold_out_valid", 32'(out_valid), 1);
         check("hold_in_ready", 32'(in_ready), 0);
         check("hold_diff", 32'(diff), 32'(held));
         check("hold_borr", 32'(borr), 32'(exp[W]));
         check("hold_ovf", 32'(ovf), 32'(exp[W+1]));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("release_out_valid", 32'(out_valid), 0);
      check("release_in_ready", 32'(in_ready), 1);
   endtask

   initial begin
      logic [W-1:0] pa [4];
      logic [W-1:0] pb [4];
      logic         pbin [4];
      logic [W+1:0] expq [$];
      logic [W+1:0] e;
      int idx, nout, last_acc;
      logic pre_acc;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; bin = 1'b0;
      #12;
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_diff", 32'(diff), 0);
      check("rst_borr", 32'(borr), 0);
      check("rst_ovf", 32'(ovf), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(8'h05, 8'h03, 1'b0, 0);
      run_op(8'h03, 8'h05, 1'b0, 0);
      run_op(8'h00, 8'h00, 1'b1, 0);
      run_op(8'h80, 8'h01, 1'b0, 0);
      run_op(8'h7F, 8'hFF, 1'b0, 0);
      run_op(8'hFF, 8'hFF, 1'b1, 0);
      run_op(8'hA5, 8'h3C, 1'b1, 5);

      // Reset in the middle of RUN.
      a = 8'hC3; b = 8'h11; bin = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 0);
      check("midrst_in_ready", 32'(in_ready), 1);
      check("midrst_diff", 32'(diff), 0);
      check("midrst_borr", 32'(borr), 0);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(8'h10, 8'h01, 1'b0, 0);

      for (int i = 0; i < 24; i++)
         run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

      // Back-to-back with in_valid and out_ready held high.
      for (int i = 0; i < 4; i++) begin
         pa[i] = W'($urandom); pb[i] = W'($urandom); pbin[i] = 1'($urandom);
      end
      idx = 0; nout = 0; last_acc = -1;
      out_ready = 1'b1;
      a = pa[0]; b = pb[0]; bin = pbin[0]; in_valid = 1'b1;
      for (int cyc = 0; cyc < 200 && nout < 4; cyc++) begin
         pre_acc = in_ready && in_valid;
         if (out_valid) begin
            if (expq.size() == 0) begin
               check("b2b_unexpected_out", 1, 0);
            end else begin
               e = expq.pop_front();
               check("b2b_diff", 32'(diff), 32'(e[W-1:0]));
               check("b2b_borr", 32'(borr), 32'(e[W]));
               check("b2b_ovf", 32'(ovf), 32'(e[W+1]));
            end
            nout++;
         end
         @(posedge clk); #1;
         if (pre_acc) begin
            if (last_acc >= 0) check("b2b_spacing", cyc - last_acc, W + 2);
            last_acc = cyc;
            expq.push_back(model(pa[idx], pb[idx], pbin[idx]));
            idx++;
            if (idx < 4) begin
               a = pa[idx]; b = pb[idx]; bin = pbin[idx];
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      check("b2b_count", nout, 4);
      out_ready = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor that computes a − b − bin LSB-first, one bit per clock.
- Each cycle it evaluates the same difference/borrow cell the half-subtractor implements, extended with a registered borrow chain.
- Sits between an operand source and a result consumer; both sides use valid/ready handshakes.
- Area-cheap alternative to a parallel ripple subtractor for the adder-subtractor datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).
- CNT_W, $clog2(WIDTH)+1, bit-counter width (derived, not overridden).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a, b, bin are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend, unsigned or two's complement.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in for the LSB.
- out_valid  output  1  diff, borr, ovf are valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  a − b − bin modulo 2^WIDTH.
- borr  output  1  final borrow-out; 1 iff unsigned a < b + bin.
- ovf  output  1  signed overflow of the subtraction.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, diff=0, borr=0, ovf=0, counter=0, shift registers=0.
- FSM states:
  - IDLE: in_ready=1. If in_valid is high at a clock edge, capture a and b into shift registers and bin into the borrow flop, clear the counter, and go to RUN.
  - RUN: in_ready=0, out_valid=0. Each edge processes bit i:
    - d = a_i ^ b_i ^ br
    - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
    - Shift d into diff from the MSB side; shift the operand registers right; increment the counter.
    - On the edge that processes bit WIDTH−1, go to DONE.
  - DONE: out_valid=1, in_ready=0. diff, borr and ovf are held stable while out_ready is low. When out_valid and out_ready are both high at an edge, go to IDLE.
- Latency: the accept edge is E0. Bits are processed at edges E1..EWIDTH. out_valid rises after edge EWIDTH.
- Throughput: at most one operation per WIDTH+2 cycles. in_ready is never high while out_valid is high, so there is no simultaneous accept and emit.
- borr equals the borrow flop after bit WIDTH−1 is processed.
- ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]). The captured a[MSB] and b[MSB] are kept in dedicated flops, because the shift registers are consumed during RUN.
- Output registers keep their last values in IDLE. They are meaningful only while out_valid=1.
- in_valid while in_ready=0 is ignored and has no effect on state. Operand inputs are sampled only at the accept edge.
- Reset asserted mid-RUN or in DONE aborts immediately: outputs return to reset values and the result is discarded.
- Wrap-around: diff is always modulo 2^WIDTH; no saturation.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0 -> after 8 RUN edges out_valid=1, diff=0x02, borr=0, ovf=0.
- a=0x03, b=0x05, bin=0 -> diff=0xFE, borr=1, ovf=0. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, borr=1, ovf=0.
- a=0x80, b=0x01 -> diff=0x7F, borr=0, ovf=1. Then a=0x7F, b=0xFF -> diff=0x80, borr=1, ovf=1.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid rises -> out_valid, diff and borr stay stable; in_ready stays 0; in_valid pulses are ignored. Then out_ready=1 -> IDLE next edge, in_ready=1.
- Reset mid-RUN: drop rst_n after 3 RUN edges -> out_valid=0, diff=0, in_ready=1 with no clock needed. The next operation a=0x10, b=0x01 gives diff=0x0F, borr=0.
- Back-to-back: keep in_valid=1 and out_ready=1 with 4 random operand pairs -> each result matches a − b − bin mod 256, and each is accepted WIDTH+2 cycles apart.
